axi_lite_mem_arbiter: RTL and testbench

- Shares the single AXI-lite memory slave port between the IFU (instruction fetch, read-only) and the WBU load/store path (read and write).
- Grants one master at a time and allows one outstanding transaction.
- Muxes the request channels to the slave and steers responses back to the granted master only.
- Sits between the IFU/WBU AXI master ports and the memory/crossbar slave.

---
 rtl/axi_lite_mem_arbiter_pkg.sv | 15 +
 rtl/axi_lite_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types and AXI response codes for the memory arbiter, IFU, WBU and memory model.
package axi_lite_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_mem_arbiter.sv
// Single-outstanding AXI-lite arbiter sharing one memory slave between the IFU (read-only)
// and the WBU load/store path. Muxing is driven only by the registered grant state.
module axi_lite_mem_arbiter
  import axi_lite_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic                busy
);

  arb_state_t state, state_next;
  logic       ar_done, aw_done, w_done;
  logic       rd_exit, wr_exit;

  assign rd_exit = ((state == IFU_RD) || (state == LSU_RD)) && s_rvalid && s_rready;
  assign wr_exit = (state == LSU_WR) && s_bvalid && s_bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (rd_exit)
        ar_done <= 1'b0;
      else if (s_arvalid && s_arready)
        ar_done <= 1'b1;
      if (wr_exit) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (s_awvalid && s_awready) aw_done <= 1'b1;
        if (s_wvalid && s_wready)   w_done  <= 1'b1;
      end
    end
  end

  // Fixed priority: the pipeline stalls on the LSU, so writes then LSU reads win over fetch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (lsu_awvalid)      state_next = LSU_WR;
        else if (lsu_arvalid) state_next = LSU_RD;
        else if (ifu_arvalid) state_next = IFU_RD;
      end
      IFU_RD, LSU_RD: if (rd_exit) state_next = IDLE;
      LSU_WR:         if (wr_exit) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awaddr    = '0;
    s_awvalid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    // Outputs are quiet while rst is high, even before the state register has cleared.
    if (!rst) begin
      unique case (state)
        IFU_RD: begin
          s_araddr    = ifu_araddr;
          s_arvalid   = ifu_arvalid && !ar_done;
          ifu_arready = s_arready && !ar_done;
          ifu_rdata   = s_rdata;
          ifu_rresp   = s_rresp;
          ifu_rvalid  = s_rvalid;
          s_rready    = ifu_rready;
        end
        LSU_RD: begin
          s_araddr    = lsu_araddr;
          s_arvalid   = lsu_arvalid && !ar_done;
          lsu_arready = s_arready && !ar_done;
          lsu_rdata   = s_rdata;
          lsu_rresp   = s_rresp;
          lsu_rvalid  = s_rvalid;
          s_rready    = lsu_rready;
        end
        LSU_WR: begin
          s_awaddr    = lsu_awaddr;
          s_awvalid   = lsu_awvalid && !aw_done;
          lsu_awready = s_awready && !aw_done;
          s_wdata     = lsu_wdata;
          s_wstrb     = lsu_wstrb;
          s_wvalid    = lsu_wvalid && !w_done;
          lsu_wready  = s_wready && !w_done;
          lsu_bresp   = s_bresp;
          lsu_bvalid  = s_bvalid;
          s_bready    = lsu_bready;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed self-checking bench for axi_lite_mem_arbiter; the test harness plays both masters and the slave.
module tb_axi_lite_mem_arbiter;
  import axi_lite_mem_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] ifu_araddr, lsu_araddr, lsu_awaddr, s_araddr, s_awaddr;
  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [DATA_W-1:0] ifu_rdata, lsu_rdata, lsu_wdata, s_rdata, s_wdata;
  logic [DATA_W/8-1:0] lsu_wstrb, s_wstrb;
  logic [1:0] ifu_rresp, lsu_rresp, lsu_bresp, s_rresp, s_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic busy;

  int vectors = 0;
  int miscompares = 0;
  int aw_pulses = 0;
  logic count_aw = 1'b0;

  always #5 clk = ~clk;

  axi_lite_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .busy(busy)
  );

  // Mid-cycle sampling counts how many cycles the LSU sees an AW handshake.
  always @(negedge clk) if (count_aw && lsu_awready) aw_pulses++;

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    rst = 1'b1;
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0; lsu_bready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = OKAY; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = OKAY; s_bvalid = 0;

    applyStimulus(2);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_s_arvalid", s_arvalid, 0);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_s_rready", s_rready, 0);

    $display("[TB] IFU read alone");
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_rready = 1; s_arready = 1;
    #1;
    checkOutput("ifu_idle_arready", ifu_arready, 0);
    checkOutput("ifu_idle_s_arvalid", s_arvalid, 0);
    applyStimulus(1);
    checkOutput("ifu_busy", busy, 1);
    checkOutput("ifu_s_arvalid", s_arvalid, 1);
    checkOutput("ifu_s_araddr", s_araddr, 32'h8000_0000);
    checkOutput("ifu_arready", ifu_arready, 1);
    applyStimulus(1);
    s_arready = 0;
    #1;
    checkOutput("ifu_ar_done_gate", s_arvalid, 0);
    checkOutput("ifu_rvalid_early", ifu_rvalid, 0);
    ifu_arvalid = 0;
    applyStimulus(1);
    s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = OKAY;
    #1;
    checkOutput("ifu_rvalid", ifu_rvalid, 1);
    checkOutput("ifu_rdata", ifu_rdata, 32'h0000_0413);
    checkOutput("ifu_lsu_rvalid", lsu_rvalid, 0);
    checkOutput("ifu_s_rready", s_rready, 1);
    applyStimulus(1);
    s_rvalid = 0;
    checkOutput("ifu_exit_busy", busy, 0);

    $display("[TB] simultaneous IFU and LSU reads");
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0000; lsu_rready = 1;
    applyStimulus(1);
    checkOutput("sim_s_araddr_lsu", s_araddr, 32'h8000_0000);
    s_arready = 1;
    #1;
    checkOutput("sim_lsu_arready", lsu_arready, 1);
    checkOutput("sim_ifu_arready", ifu_arready, 0);
    applyStimulus(1);
    lsu_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hCAFE_F00D;
    #1;
    checkOutput("sim_lsu_rdata", lsu_rdata, 32'hCAFE_F00D);
    checkOutput("sim_ifu_rvalid", ifu_rvalid, 0);
    applyStimulus(1);
    s_rvalid = 0;
    checkOutput("sim_idle_gap", busy, 0);
    checkOutput("sim_idle_ifu_arready", ifu_arready, 0);
    applyStimulus(1);
    checkOutput("sim_s_araddr_ifu", s_araddr, 32'h8000_0100);
    s_arready = 1;
    applyStimulus(1);
    ifu_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h1234_5678;
    #1;
    checkOutput("sim_ifu_rdata", ifu_rdata, 32'h1234_5678);
    applyStimulus(1);
    s_rvalid = 0;

    $display("[TB] split write");
    count_aw = 1;
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_1000;
    lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'h0F; lsu_bready = 1;
    applyStimulus(1);
    checkOutput("wr_s_awvalid", s_awvalid, 1);
    checkOutput("wr_s_awaddr", s_awaddr, 32'h8000_1000);
    checkOutput("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
    checkOutput("wr_s_wstrb", s_wstrb, 4'h0F);
    applyStimulus(1);
    s_awready = 1;
    #1;
    checkOutput("wr_lsu_awready", lsu_awready, 1);
    applyStimulus(1);
    checkOutput("wr_aw_done_valid", s_awvalid, 0);
    checkOutput("wr_aw_done_ready", lsu_awready, 0);
    checkOutput("wr_s_wvalid_held", s_wvalid, 1);
    applyStimulus(1);
    s_wready = 1;
    #1;
    checkOutput("wr_lsu_wready", lsu_wready, 1);
    applyStimulus(1);
    checkOutput("wr_w_done_valid", s_wvalid, 0);
    checkOutput("wr_w_done_ready", lsu_wready, 0);
    lsu_awvalid = 0; lsu_wvalid = 0;
    s_bvalid = 1; s_bresp = SLVERR;
    #1;
    checkOutput("wr_lsu_bvalid", lsu_bvalid, 1);
    checkOutput("wr_lsu_bresp", lsu_bresp, SLVERR);
    applyStimulus(1);
    s_bvalid = 0; s_awready = 0; s_wready = 0; count_aw = 0;
    checkOutput("wr_exit_busy", busy, 0);
    checkOutput("wr_aw_pulses", aw_pulses, 1);

    $display("[TB] error response");
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0200;
    applyStimulus(1);
    s_arready = 1;
    applyStimulus(1);
    lsu_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rresp = DECERR; s_rdata = '0;
    #1;
    checkOutput("err_lsu_rvalid", lsu_rvalid, 1);
    checkOutput("err_lsu_rresp", lsu_rresp, 2'b11);
    applyStimulus(1);
    s_rvalid = 0; s_rresp = OKAY;
    checkOutput("err_exit_busy", busy, 0);

    $display("[TB] back-pressure");
    ifu_arvalid = 1; ifu_araddr = 32'h8000_2000;
    applyStimulus(1);
    lsu_arvalid = 1; lsu_araddr = 32'h8000_3000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_s_arvalid", s_arvalid, 1);
      checkOutput("bp_s_araddr", s_araddr, 32'h8000_2000);
      checkOutput("bp_lsu_arready", lsu_arready, 0);
      applyStimulus(1);
    end
    s_arready = 1;
    applyStimulus(1);
    ifu_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h0000_0013;
    #1;
    checkOutput("bp_ifu_rvalid", ifu_rvalid, 1);
    checkOutput("bp_lsu_rvalid", lsu_rvalid, 0);
    applyStimulus(1);
    s_rvalid = 0;
    checkOutput("bp_idle_gap", busy, 0);
    applyStimulus(1);
    checkOutput("bp_lsu_granted_addr", s_araddr, 32'h8000_3000);
    s_arready = 1;
    applyStimulus(1);
    lsu_arvalid = 0; s_arready = 0; s_rvalid = 1;
    applyStimulus(1);
    s_rvalid = 0;

    $display("[TB] reset mid-write");
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_4000; lsu_wvalid = 1; lsu_wdata = 32'h5555_AAAA;
    applyStimulus(1);
    s_awready = 1;
    applyStimulus(1);
    s_awready = 0; lsu_awvalid = 0;
    rst = 1;
    #1;
    checkOutput("rstw_s_wvalid_in_rst", s_wvalid, 0);
    applyStimulus(1);
    rst = 0;
    checkOutput("rstw_busy", busy, 0);
    checkOutput("rstw_lsu_wready", lsu_wready, 0);
    lsu_wvalid = 0;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0004;
    applyStimulus(1);
    checkOutput("rstw_ifu_s_araddr", s_araddr, 32'h8000_0004);
    s_arready = 1;
    applyStimulus(1);
    ifu_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h0000_0093;
    #1;
    checkOutput("rstw_ifu_rdata", ifu_rdata, 32'h0000_0093);
    applyStimulus(1);
    s_rvalid = 0;
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_5000;
    applyStimulus(1);
    checkOutput("rstw_aw_done_cleared", s_awvalid, 1);
    lsu_awvalid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
